// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - round-robin arbiter sharing one RAM command port between requesters A and B
module spi_ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [ADDR_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [ADDR_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [ADDR_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W+1:0] ram_din,
  output logic              ram_rx_valid,
  input  logic [ADDR_W-1:0] ram_dout,
  input  logic              ram_tx_valid
);

  typedef enum logic [1:0] {IDLE, CMD1, CMD2, WAIT_RD} state_t;

  state_t            state;
  logic              last_grant;  // 1 = B was granted last
  logic              owner;       // 1 = B owns the current transaction
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wdata_q;
  logic [3:0]        cnt;

  logic              grant_a;
  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_wdata;

  always_comb begin
    grant_a   = (state == IDLE) && a_req_valid && (!b_req_valid || last_grant);
    grant_b   = (state == IDLE) && b_req_valid && !grant_a;
    sel_we    = grant_a ? a_req_we    : b_req_we;
    sel_addr  = grant_a ? a_req_addr  : b_req_addr;
    sel_wdata = grant_a ? a_req_wdata : b_req_wdata;
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      a_rsp_valid  <= 1'b0;
      b_rsp_valid  <= 1'b0;
    end else begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            we_q         <= sel_we;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            owner        <= grant_b;
            last_grant   <= grant_b;
            ram_din      <= {(sel_we ? 2'b00 : 2'b10), sel_addr};
            ram_rx_valid <= 1'b1;
            state        <= CMD1;
          end
        end
        CMD1: begin
          ram_din <= {(we_q ? 2'b01 : 2'b11), (we_q ? wdata_q : {ADDR_W{1'b0}})};
          state   <= CMD2;
        end
        CMD2: begin
          ram_rx_valid <= 1'b0;
          if (we_q) begin
            a_rsp_valid <= !owner;
            b_rsp_valid <= owner;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            state       <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // ram_tx_valid was cleared by the RAM on CMD1, so any high here is fresh
          if (ram_tx_valid) begin
            a_rsp_valid <= !owner;
            b_rsp_valid <= owner;
            rsp_rdata   <= ram_dout;
            rsp_err     <= 1'b0;
            state       <= IDLE;
          end else if (cnt == 4'(TIMEOUT - 1)) begin
            a_rsp_valid <= !owner;
            b_rsp_valid <= owner;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - scoreboard bench for spi_ram_arbiter with a behavioural RAM and reference model
module tb_spi_ram_arbiter;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [7:0] a_req_addr, a_req_wdata;
  logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [7:0] b_req_addr, b_req_wdata;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;

  spi_ram_arbiter #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: two-word commands, read data valid until the next command
  logic [7:0] ram_mem [256];
  logic [7:0] ram_a = 8'h00;
  logic       stall_cur = 1'b0;
  always @(posedge clk) begin
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: begin ram_a <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        2'b01: ram_mem[ram_a] <= ram_din[7:0];
        2'b10: begin ram_a <= ram_din[7:0]; ram_tx_valid <= 1'b0; end
        default: if (!stall_cur) begin ram_dout <= ram_mem[ram_a]; ram_tx_valid <= 1'b1; end
      endcase
    end
  end

  typedef struct {
    logic       owner;
    logic [7:0] rdata;
    logic       err;
    int         due;
  } rsp_t;

  rsp_t       rsp_q [$];
  logic [9:0] cmd_q [$];
  logic [7:0] ref_mem [256];
  logic       m_last = 1'b1;
  bit         m_busy = 1'b0;
  int         m_due = 0;
  bit         force_stall = 1'b0;
  bit         rand_stall = 1'b0;
  int         pass_cnt = 0;
  int         total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: predicts grants, command words and responses at transaction level
  always @(negedge clk) begin
    bit ga, gb, idle, we;
    logic [7:0] ad, wd;
    rsp_t r;
    if (!rst_n) begin
      rsp_q.delete();
      cmd_q.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
    end else begin
      idle = !m_busy || (cyc >= m_due);
      ga = idle && a_req_valid && (!b_req_valid || m_last);
      gb = idle && b_req_valid && !ga;
      chk("a_req_ready", a_req_ready, ga);
      chk("b_req_ready", b_req_ready, gb);
      if (ga || gb) begin
        we = ga ? a_req_we : b_req_we;
        ad = ga ? a_req_addr : b_req_addr;
        wd = ga ? a_req_wdata : b_req_wdata;
        m_last = gb;
        m_busy = 1'b1;
        stall_cur = !we && (force_stall || (rand_stall && $urandom_range(0, 3) == 0));
        if (we) begin
          ref_mem[ad] = wd;
          r = '{gb, 8'h00, 1'b0, cyc + 3};
          cmd_q.push_back({2'b00, ad});
          cmd_q.push_back({2'b01, wd});
        end else begin
          if (stall_cur) r = '{gb, 8'h00, 1'b1, cyc + 3 + TIMEOUT};
          else           r = '{gb, ref_mem[ad], 1'b0, cyc + 4};
          cmd_q.push_back({2'b10, ad});
          cmd_q.push_back({2'b11, 8'h00});
        end
        m_due = r.due;
        rsp_q.push_back(r);
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    rsp_t r;
    logic [9:0] c;
    if (rst_n) begin
      chk("rsp_exclusive", a_rsp_valid & b_rsp_valid, 0);
      if (a_rsp_valid || b_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_rsp: a=%0b b=%0b with nothing outstanding (cycle %0d)", a_rsp_valid, b_rsp_valid, cyc);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_owner", b_rsp_valid, r.owner);
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_cycle", cyc, r.due);
        end
      end
      if (ram_rx_valid) begin
        if (cmd_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_cmd: ram_din=%0h with nothing expected (cycle %0d)", ram_din, cyc);
        end else begin
          c = cmd_q.pop_front();
          chk("ram_din", ram_din, c);
        end
      end
    end
  end

  task automatic drive(input bit ae, input bit awe, input logic [7:0] aad, input logic [7:0] awd,
                       input bit be, input bit bwe, input logic [7:0] bad, input logic [7:0] bwd);
    bit acca, accb;
    a_req_valid = ae; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = be; b_req_we = bwe; b_req_addr = bad; b_req_wdata = bwd;
    for (int i = 0; i < 60 && (a_req_valid || b_req_valid); i++) begin
      @(negedge clk);
      acca = a_req_valid && a_req_ready;
      accb = b_req_valid && b_req_ready;
      @(posedge clk); #1;
      if (acca) a_req_valid = 1'b0;
      if (accb) b_req_valid = 1'b0;
    end
    if (a_req_valid || b_req_valid) begin
      total++;
      $display("FAIL drive_timeout: request not accepted within 60 cycles");
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && rsp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (rsp_q.size() > 0) begin
      total++;
      $display("FAIL wait_idle_timeout: %0d responses still outstanding", rsp_q.size());
    end
  endtask

  initial begin
    int g_side [$];
    int g_cyc [$];
    bit seen;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ram_din", ram_din, 0);
    chk("reset_ram_rx_valid", ram_rx_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_a_rsp_valid", a_rsp_valid, 0);
    chk("reset_b_rsp_valid", b_rsp_valid, 0);
    rst_n = 1'b1;

    // Both requesters hammer writes from reset: grants must alternate A,B,... 3 cycles apart
    a_req_valid = 1; b_req_valid = 1; a_req_we = 1; b_req_we = 1;
    for (int i = 0; i < 13; i++) begin
      a_req_addr = 8'($urandom); a_req_wdata = 8'($urandom);
      b_req_addr = 8'($urandom); b_req_wdata = 8'($urandom);
      @(negedge clk);
      if (a_req_ready) begin g_side.push_back(0); g_cyc.push_back(cyc); end
      if (b_req_ready) begin g_side.push_back(1); g_cyc.push_back(cyc); end
      @(posedge clk); #1;
    end
    a_req_valid = 0; b_req_valid = 0;
    chk("rr_grant_count", g_side.size(), 5);
    for (int k = 0; k < g_side.size(); k++) begin
      chk("rr_grant_side", g_side[k], k % 2);
      if (k > 0) chk("rr_grant_spacing", g_cyc[k] - g_cyc[k-1], 3);
    end
    wait_idle();

    drive(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00);
    wait_idle();

    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h11);
    wait_idle();
    drive(1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'h55);
    wait_idle();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    wait_idle();

    force_stall = 1'b1;
    drive(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00);
    wait_idle();
    force_stall = 1'b0;

    drive(1, 1, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00);
    wait_idle();

    // Reset while the read is in CMD1: abandoned silently, A wins next tie
    a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h3C;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = a_req_ready;
    end
    @(posedge clk); #1;
    a_req_valid = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ram_rx_valid", ram_rx_valid, 0);
    chk("midreset_ram_din", ram_din, 0);
    rst_n = 1'b1;
    a_req_valid = 1; a_req_we = 1; a_req_addr = 8'h20; a_req_wdata = 8'h77;
    b_req_valid = 1; b_req_we = 1; b_req_addr = 8'h21; b_req_wdata = 8'h88;
    @(negedge clk);
    chk("post_reset_a_ready", a_req_ready, 1);
    chk("post_reset_b_ready", b_req_ready, 0);
    @(posedge clk); #1;
    drive(0, 1, 8'h20, 8'h77, 1, 1, 8'h21, 8'h88);
    wait_idle();

    rand_stall = 1'b1;
    for (int i = 0; i < 500; i++) begin
      a_req_valid = 1'($urandom); a_req_we = 1'($urandom);
      a_req_addr = 8'($urandom_range(0, 15)); a_req_wdata = 8'($urandom);
      b_req_valid = 1'($urandom); b_req_we = 1'($urandom);
      b_req_addr = 8'($urandom_range(0, 15)); b_req_wdata = 8'($urandom);
      @(posedge clk); #1;
    end
    a_req_valid = 0; b_req_valid = 0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares one single_port_ram command interface between two requesters, A and B, using round-robin arbitration.
- Converts each accepted write or read transaction into the RAM's two-word command sequence on a 10-bit command bus: opcode in bits [9:8], payload in bits [7:0].
- Returns an acknowledgement, read data and a timeout error to the requester that issued the transaction.
- Sits between the SPI slave front end and a second on-chip master (debug/DMA port) on one side, and the RAM on the other.

Parameters:
- ADDR_W, 8: address and data width; RAM command width is ADDR_W+2.
- TIMEOUT, 4: maximum cycles spent in WAIT_RD waiting for ram_tx_valid before an error response (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- a_req_valid  in  1  requester A transaction request
- a_req_ready  out  1  A accepted this cycle (combinational)
- a_req_we  in  1  1=write, 0=read
- a_req_addr  in  8  A address
- a_req_wdata  in  8  A write data
- a_rsp_valid  out  1  one-cycle response pulse to A
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid  (same as A, for requester B)
- rsp_rdata  out  8  read data; shared, qualified by a_rsp_valid/b_rsp_valid
- rsp_err  out  1  read timeout flag; shared, qualified the same way
- ram_din  out  10  command word to RAM
- ram_rx_valid  out  1  command strobe to RAM
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-data valid (stays high until the next RAM command)

Behaviour:
- Reset: state IDLE; the following outputs/registers are 0: ram_din, ram_rx_valid, rsp_rdata, rsp_err, a_rsp_valid, b_rsp_valid, timeout counter. last_grant=B, so A wins the first tie.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and ram_rx_valid is 0 from the next cycle.
- States: IDLE, CMD1, CMD2, WAIT_RD.
- Grant (IDLE only): a single requester is granted. If both request, grant the one that is not last_grant. x_req_ready = IDLE && granted. Outside IDLE both readys are 0.
- Accept edge E0 (valid && ready):
  - latch we, addr, wdata and owner; update last_grant.
  - drive ram_din={we?2'b00:2'b10, addr}, ram_rx_valid=1; go to CMD1.
- Edge E1 (CMD1): drive ram_din={we?2'b01:2'b11, we?wdata:8'h00}, ram_rx_valid=1; go to CMD2.
- Edge E2 (CMD2): ram_rx_valid=0; ram_din holds its value.
  - Write: owner rsp_valid=1 for one cycle, rsp_err=0, rsp_rdata=0; go to IDLE.
  - Read: clear the timeout counter; go to WAIT_RD.
- WAIT_RD, each edge:
  - If ram_tx_valid=1: rsp_rdata<=ram_dout, rsp_err<=0, owner rsp_valid pulse; go to IDLE.
  - Else if counter==TIMEOUT-1: rsp_rdata<=0, rsp_err<=1, owner rsp_valid pulse; go to IDLE.
  - Else counter+1.
- ram_tx_valid is trusted only in WAIT_RD. Any stale high from a previous read is cleared by the RAM on CMD1 of the current transaction.
- Latency with a normal RAM:
  - write: rsp_valid is high in the cycle after E2, i.e. 3 cycles after accept.
  - read: ram_tx_valid is high in the cycle after E2; rsp_valid is high in the cycle after E3, i.e. 4 cycles after accept.
- Throughput: the response cycle is an IDLE cycle, so a new request may be accepted in the same cycle as the previous response.
- a_rsp_valid and b_rsp_valid are never high together. rsp_rdata and rsp_err hold their values until the next response.
- Requester inputs are don't-care except on the accept edge; the arbiter sends only latched values to the RAM.
- A requester that deasserts valid before acceptance loses nothing; no request is queued.

Test Plan:
- A write addr 0x3C data 0xA5, then A read 0x3C:
  - ram_din sequence 0x03C, 0x1A5, then 0x23C, 0x300;
  - a_rsp_valid 3 cycles after write accept;
  - read response 4 cycles after accept with rsp_rdata=0xA5, rsp_err=0.
- A and B both request continuously (both writes) from reset:
  - grants alternate A, B, A, B;
  - each grant is 3 cycles apart;
  - b_rsp_valid never fires for an A transaction.
- B write 0x10=0x55 while A read 0x10 is requested in the same cycle after a B grant: A is granted first; A rdata is the old content; the following B write then takes effect. A subsequent A read returns 0x55.
- RAM model holds ram_tx_valid=0 during a read with TIMEOUT=4: rsp_valid 4 cycles after entering WAIT_RD, with rsp_err=1 and rsp_rdata=0x00.
- Assert rst_n=0 during CMD1 of a read: next cycle ram_rx_valid=0 and state is IDLE; no rsp_valid ever fires; the next request after reset is granted to A.
- Read at address 0xFF after a write of 0x00 to 0xFF: ram_din=0x2FF, then 0x300; rsp_rdata=0x00; no address wrap issue.
